traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
- Master sequencer for a two-road intersection: main road, side road, pedestrian crossing.
- Generates the 1-second tick that enables the light countdown timer (light_counter).
- Supplies the timer with the reload duration of the next phase and advances the phase FSM when the timer reports finish on a tick.
- Adds a latched pedestrian request, a walk phase, and a safe flashing-yellow night mode.

Parameters:
- CLK_PER_TICK, 50_000_000: clk cycles per 1-second tick (sim uses 4).
- MAIN_GREEN_SEC, 18: main green reload value; fixed equal to the timer's reset value.
- SIDE_GREEN_SEC, 12: side green reload value.
- YELLOW_SEC, 3: yellow reload value (both roads).
- ALL_RED_SEC, 1: all-red clearance reload value.
- WALK_SEC, 8: pedestrian walk reload value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ped_req  in  1  async pedestrian button, level
- flash_mode  in  1  async night-mode request, level
- finish  in  1  timer count==0 flag
- tick  out  1  1-clk pulse every CLK_PER_TICK cycles; drives timer en
- light_second  out  5  reload duration for the phase after the current one
- main_light  out  3  {R,Y,G} main road
- side_light  out  3  {R,Y,G} side road
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding

Behaviour:
- Reset values:
  - state = MAIN_GREEN, tick div counter = 0, tick = 0.
  - ped_pending = 0, sync flops = 0, flash_phase = 0.
  - main_light = 001, side_light = 100, walk = 0, phase = 0.
- Tick divider:
  - Counts 0..CLK_PER_TICK-1; tick = 1 for exactly one cycle when count == CLK_PER_TICK-1, then wraps to 0.
  - Runs free in every state.
- Phase timing:
  - A phase with reload value N lasts N+1 ticks (timer counts N..0, reloads on tick at 0).
  - Advance condition adv = tick && finish. The state register updates in the same cycle the timer reloads.
- States and successors (encoding 0..6):
  - MAIN_GREEN(0) -> MAIN_YELLOW(1) -> ALL_RED_M(2) -> SIDE_GREEN(3) -> SIDE_YELLOW(4) -> ALL_RED_S(5).
  - From ALL_RED_S: PED_WALK(6) if ped_pending, else MAIN_GREEN.
  - PED_WALK -> MAIN_GREEN.
  - FLASH(7): see below.
- light_second is combinational from state, ped_pending and flash_sync, and equals the reload value of the successor state.
  - Example: in MAIN_GREEN it outputs YELLOW_SEC.
  - FLASH reload value is 0.
- Pedestrian request:
  - ped_req passes through a 2-flop synchroniser; its rising edge sets ped_pending.
  - ped_pending clears on the adv cycle entering PED_WALK.
  - A rising edge while in PED_WALK, or in the entry cycle, is dropped.
  - Repeated presses while pending have no effect (single walk served).
- Flash mode:
  - flash_mode passes through a 2-flop synchroniser to flash_sync.
  - Entry: only from ALL_RED_M or ALL_RED_S on adv with flash_sync = 1. State becomes FLASH and light_second = 0, so the timer holds at 0.
  - In FLASH, flash_phase toggles on every tick.
  - Exit: on the first tick with flash_sync = 0, go to ALL_RED_S with light_second = ALL_RED_SEC.
  - ped_pending is held during FLASH and served after exit.
- Light decode (combinational from registered state):
  - MAIN_GREEN: M=001, S=100.
  - MAIN_YELLOW: M=010, S=100.
  - ALL_RED_x: 100 / 100.
  - SIDE_GREEN: M=100, S=001.
  - SIDE_YELLOW: M=100, S=010.
  - PED_WALK: 100 / 100, walk = 1.
  - FLASH: M = {0, flash_phase, 0}, S = {flash_phase, 0, 0}.
  - Never green/yellow on both roads at once.
- Reset mid-operation returns to MAIN_GREEN immediately. Because the timer also resets to 18, the two stay aligned.

Decomposition:
- Shared package traffic_pkg holds:
  - state encodings,
  - light bit positions (R=2, Y=1, G=0),
  - default durations and the 5-bit duration width.
- One sub-module, tick_gen (parameterised divider producing tick), reused by other timing blocks.
- The 2-flop synchroniser is inline.

Test Plan (CLK_PER_TICK=4, light_counter connected):
- Reset, no inputs -> main green 19 ticks (76 clks), yellow 4, all-red 2, side green 13, yellow 4, all-red 2, back to MAIN_GREEN; phase sequence 0,1,2,3,4,5,0.
- Pulse ped_req during SIDE_GREEN -> after ALL_RED_S, PED_WALK with walk = 1 for 9 ticks, then MAIN_GREEN. Next cycle without a press skips PED_WALK.
- flash_mode = 1 during MAIN_GREEN -> no change until ALL_RED_M ends, then FLASH. main Y toggles each tick, side R toggles, timer count stays 0.
- flash_mode = 0 while in FLASH -> on the next tick enter ALL_RED_S (count reloads 1), then MAIN_GREEN.
- ped_req pressed 3 times in SIDE_GREEN and again during PED_WALK -> exactly one walk phase served; ped_pending = 0 after the walk.
- Assert rst_n low in SIDE_YELLOW -> outputs return to reset values asynchronously. After release, the first phase advance occurs 19 ticks later.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection sequencer: phase encodings, lamp bit
// positions and default phase durations (seconds).
package traffic_pkg;

  localparam int DUR_W = 5;

  localparam int LIGHT_R = 2;
  localparam int LIGHT_Y = 1;
  localparam int LIGHT_G = 0;

  localparam logic [2:0] LAMP_R = 3'(1 << LIGHT_R);
  localparam logic [2:0] LAMP_Y = 3'(1 << LIGHT_Y);
  localparam logic [2:0] LAMP_G = 3'(1 << LIGHT_G);

  localparam int DEF_MAIN_GREEN_SEC = 18;
  localparam int DEF_SIDE_GREEN_SEC = 12;
  localparam int DEF_YELLOW_SEC     = 3;
  localparam int DEF_ALL_RED_SEC    = 1;
  localparam int DEF_WALK_SEC       = 8;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_M   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_S   = 3'd5,
    PED_WALK    = 3'd6,
    FLASH       = 3'd7
  } phase_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every CLK_PER_TICK clocks, first tick
// CLK_PER_TICK-1 cycles after reset release.
module tick_gen #(
  parameter int CLK_PER_TICK = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CNT_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_TICK - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for main road, side road and pedestrian crossing; drives the
// external countdown timer with tick and the reload value of the next phase.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_PER_TICK   = 50_000_000,
  parameter int MAIN_GREEN_SEC = DEF_MAIN_GREEN_SEC,
  parameter int SIDE_GREEN_SEC = DEF_SIDE_GREEN_SEC,
  parameter int YELLOW_SEC     = DEF_YELLOW_SEC,
  parameter int ALL_RED_SEC    = DEF_ALL_RED_SEC,
  parameter int WALK_SEC       = DEF_WALK_SEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped_req,
  input  logic             flash_mode,
  input  logic             finish,
  output logic             tick,
  output logic [DUR_W-1:0] light_second,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk,
  output logic [2:0]       phase
);
  phase_t state, succ;
  logic   ped_s1, ped_s2, ped_d, ped_rise, ped_pending;
  logic   flash_s1, flash_sync, flash_phase;
  logic   adv, step;

  function automatic logic [DUR_W-1:0] reload_of(input phase_t s);
    case (s)
      MAIN_GREEN:              return DUR_W'(MAIN_GREEN_SEC);
      SIDE_GREEN:              return DUR_W'(SIDE_GREEN_SEC);
      MAIN_YELLOW, SIDE_YELLOW: return DUR_W'(YELLOW_SEC);
      ALL_RED_M, ALL_RED_S:    return DUR_W'(ALL_RED_SEC);
      PED_WALK:                return DUR_W'(WALK_SEC);
      default:                 return '0;
    endcase
  endfunction

  tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign adv      = tick & finish;
  assign ped_rise = ped_s2 & ~ped_d;
  // FLASH keeps the timer parked at 0, so it leaves on any tick.
  assign step     = (state == FLASH) ? tick : adv;

  always_comb begin
    succ = state;
    case (state)
      MAIN_GREEN:  succ = MAIN_YELLOW;
      MAIN_YELLOW: succ = ALL_RED_M;
      ALL_RED_M:   succ = flash_sync ? FLASH : SIDE_GREEN;
      SIDE_GREEN:  succ = SIDE_YELLOW;
      SIDE_YELLOW: succ = ALL_RED_S;
      ALL_RED_S:   succ = flash_sync ? FLASH : (ped_pending ? PED_WALK : MAIN_GREEN);
      PED_WALK:    succ = MAIN_GREEN;
      FLASH:       succ = flash_sync ? FLASH : ALL_RED_S;
      default:     succ = MAIN_GREEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_s1     <= 1'b0;
      ped_s2     <= 1'b0;
      ped_d      <= 1'b0;
      flash_s1   <= 1'b0;
      flash_sync <= 1'b0;
    end else begin
      ped_s1     <= ped_req;
      ped_s2     <= ped_s1;
      ped_d      <= ped_s2;
      flash_s1   <= flash_mode;
      flash_sync <= flash_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MAIN_GREEN;
      ped_pending <= 1'b0;
      flash_phase <= 1'b0;
    end else begin
      if (step) state <= succ;
      // Entering the walk consumes the request; a press in that same cycle is lost.
      if (adv && state == ALL_RED_S && succ == PED_WALK) begin
        ped_pending <= 1'b0;
      end else if (ped_rise && state != PED_WALK) begin
        ped_pending <= 1'b1;
      end
      if (state != FLASH) begin
        flash_phase <= 1'b0;
      end else if (tick) begin
        flash_phase <= ~flash_phase;
      end
    end
  end

  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    walk       = 1'b0;
    case (state)
      MAIN_GREEN:  main_light = LAMP_G;
      MAIN_YELLOW: main_light = LAMP_Y;
      SIDE_GREEN:  side_light = LAMP_G;
      SIDE_YELLOW: side_light = LAMP_Y;
      PED_WALK:    walk       = 1'b1;
      FLASH: begin
        main_light = flash_phase ? LAMP_Y : 3'b000;
        side_light = flash_phase ? LAMP_R : 3'b000;
      end
      default: ;
    endcase
  end

  assign light_second = reload_of(succ);
  assign phase        = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a behavioural light_counter; phase
// transitions are checked against a queue of expected (from, to, ticks) entries.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ped_req, flash_mode, finish, tick, walk;
  logic [4:0] light_second, tmr;
  logic [2:0] main_light, side_light, phase;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] from;
    logic [2:0] to;
    int         ticks;
  } exp_t;
  exp_t exp_q[$];

  initial forever #5 clk = ~clk;

  traffic_phase_ctrl #(.CLK_PER_TICK(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ped_req     (ped_req),
    .flash_mode  (flash_mode),
    .finish      (finish),
    .tick        (tick),
    .light_second(light_second),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk        (walk),
    .phase       (phase)
  );

  // light_counter: counts down on tick, reloads from light_second at zero
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tmr <= 5'd18;
    else if (tick)  tmr <= (tmr == 5'd0) ? light_second : tmr - 5'd1;
  end
  assign finish = (tmr == 5'd0);

  function automatic logic [31:0] reload_of(input logic [2:0] p);
    case (p)
      3'd0: return 32'd18;
      3'd1: return 32'd3;
      3'd2: return 32'd1;
      3'd3: return 32'd12;
      3'd4: return 32'd3;
      3'd5: return 32'd1;
      3'd6: return 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_main(input logic [2:0] p);
    case (p)
      3'd0: return 32'b001;
      3'd1: return 32'b010;
      3'd7: return 32'b000;
      default: return 32'b100;
    endcase
  endfunction

  function automatic logic [31:0] exp_side(input logic [2:0] p);
    case (p)
      3'd3: return 32'b001;
      3'd4: return 32'b010;
      3'd7: return 32'b000;
      default: return 32'b100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [2:0] from, input logic [2:0] to, input int ticks);
    exp_t e;
    e.from  = from;
    e.to    = to;
    e.ticks = ticks;
    exp_q.push_back(e);
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (phase === p) break;
    end
    chk(tag, 32'(phase), 32'(p));
  endtask

  task automatic drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic press(input int hi, input int lo);
    ped_req = 1'b1;
    repeat (hi) @(negedge clk);
    ped_req = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Monitor: pops one expectation per phase change, checks flash lamps per cycle.
  initial begin
    logic [2:0] prev;
    int         tcnt;
    logic       fp_exp;
    exp_t       e;
    prev   = 3'd0;
    tcnt   = 0;
    fp_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev   = 3'd0;
        tcnt   = 0;
        fp_exp = 1'b0;
      end else begin
        if (phase !== prev) begin
          if (exp_q.size() == 0) begin
            chk("spurious_change", 32'(phase), 32'(prev));
          end else begin
            e = exp_q.pop_front();
            chk("from_phase", 32'(prev), 32'(e.from));
            chk("to_phase", 32'(phase), 32'(e.to));
            chk("phase_ticks", 32'(tcnt), 32'(e.ticks));
            chk("main_light", 32'(main_light), exp_main(e.to));
            chk("side_light", 32'(side_light), exp_side(e.to));
            chk("walk", 32'(walk), (e.to == 3'd6) ? 32'd1 : 32'd0);
            chk("timer_reload", 32'(tmr), reload_of(e.to));
          end
          chk("no_conflict", 32'((main_light[1] | main_light[0]) & (side_light[1] | side_light[0])), 32'd0);
          prev   = phase;
          tcnt   = 0;
          fp_exp = 1'b0;
        end else if (phase === 3'd7) begin
          chk("flash_main", 32'(main_light), 32'({1'b0, fp_exp, 1'b0}));
          chk("flash_side", 32'(side_light), 32'({fp_exp, 2'b00}));
          chk("flash_timer", 32'(tmr), 32'd0);
        end
        if (tick === 1'b1) begin
          tcnt++;
          if (phase === 3'd7) fp_exp = ~fp_exp;
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    ped_req    = 1'b0;
    flash_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_main", 32'(main_light), 32'b001);
    chk("rst_side", 32'(side_light), 32'b100);
    chk("rst_walk", 32'(walk), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_light_second", 32'(light_second), 32'd3);

    // Plain cycle with no requests
    push(3'd0, 3'd1, 19); push(3'd1, 3'd2, 4); push(3'd2, 3'd3, 2);
    push(3'd3, 3'd4, 13); push(3'd4, 3'd5, 4); push(3'd5, 3'd0, 2);
    rst_n = 1'b1;
    drain(400, "drain_normal");

    // Three presses in SIDE_GREEN and one during the walk -> one walk only
    push(3'd0, 3'd1, 19); push(3'd1, 3'd2, 4); push(3'd2, 3'd3, 2);
    wait_phase(3'd3, 200, "reach_side_green");
    press(3, 3); press(3, 3); press(3, 3);
    push(3'd3, 3'd4, 13); push(3'd4, 3'd5, 4); push(3'd5, 3'd6, 2); push(3'd6, 3'd0, 9);
    wait_phase(3'd6, 200, "reach_ped_walk");
    repeat (4) @(negedge clk);
    press(3, 1);
    push(3'd0, 3'd1, 19); push(3'd1, 3'd2, 4); push(3'd2, 3'd3, 2);
    push(3'd3, 3'd4, 13); push(3'd4, 3'd5, 4); push(3'd5, 3'd0, 2);
    drain(400, "drain_ped");

    // Night mode requested in MAIN_GREEN; press held across FLASH is served after exit
    flash_mode = 1'b1;
    push(3'd0, 3'd1, 19); push(3'd1, 3'd2, 4); push(3'd2, 3'd7, 2);
    wait_phase(3'd7, 200, "reach_flash");
    repeat (2) @(negedge clk);
    press(3, 15);
    flash_mode = 1'b0;
    push(3'd7, 3'd5, 6); push(3'd5, 3'd6, 2); push(3'd6, 3'd0, 9);
    drain(300, "drain_flash");

    // Asynchronous reset in SIDE_YELLOW
    push(3'd0, 3'd1, 19); push(3'd1, 3'd2, 4); push(3'd2, 3'd3, 2); push(3'd3, 3'd4, 13);
    wait_phase(3'd4, 300, "reach_side_yellow");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_main", 32'(main_light), 32'b001);
    chk("arst_side", 32'(side_light), 32'b100);
    chk("arst_walk", 32'(walk), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_timer", 32'(tmr), 32'd18);
    repeat (2) @(negedge clk);
    push(3'd0, 3'd1, 19);
    rst_n = 1'b1;
    drain(200, "drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
